sys_reset_ctrl: RTL and testbench
=================================

Name: sys_reset_ctrl

Overview:
- Power-on and lock-supervision reset controller, sitting directly in front of the system PLL.
- Runs from the free-running board reference clock (50 MHz) and drives the PLL's active-high reset input.
- Watches the PLL lock output, retries the PLL on lock timeout, and releases the active-high system reset only after lock has been stable for a set time.
- Any loss of lock while running re-asserts system reset and restarts the sequence.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_rst is held high per PLL reset attempt (>=2).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT_LOCK before a PLL retry (>=2).
- STABLE_CYCLES, 1024: cycles of continuous synchronised lock required before sys_rst release (>=2).
- Counter width: single shared counter, width = $clog2 of the max of the three parameters.

Ports:
- clk  input  1  free-running reference clock (same clock as the PLL refclk).
- rst_n  input  1  asynchronous active-low reset.
- pll_locked  input  1  PLL lock; asynchronous to clk.
- reset_req  input  1  synchronous soft-reset request, level sensitive (e.g. debug controller).
- pll_rst  output  1  active-high PLL reset.
- sys_rst  output  1  active-high system reset; consumers re-synchronise it into their PLL clock domain.
- lock_lost  output  1  sticky flag: lock dropped while in RUN; cleared only by rst_n.
- retries  output  4  count of lock-timeout retries, saturating at 15; cleared only by rst_n.

Behaviour:
- All outputs are registered. Reset is asynchronous on rst_n low.
- Values while rst_n is low: state=PLL_RESET, counter=0, pll_rst=1, sys_rst=1, lock_lost=0, retries=0, both sync flops=0.
- pll_locked passes through a 2-flop synchroniser to give locked_s (2-cycle latency). FSM decisions use locked_s only.
- State transitions and their output updates take effect on the same clock edge. Counter is cleared on every state entry.
- PLL_RESET: pll_rst=1, sys_rst=1; counter increments. When counter==PLL_RST_CYCLES-1, go to WAIT_LOCK and pll_rst falls on that edge.
- WAIT_LOCK: pll_rst=0, sys_rst=1.
  - If locked_s=1, go to STABLE.
  - Else if counter==LOCK_TIMEOUT-1, go to PLL_RESET with retries+1 (saturating at 15).
  - Else the counter increments.
- STABLE: pll_rst=0, sys_rst=1. Checks in priority order:
  1. locked_s=0: go to WAIT_LOCK, no retry increment.
  2. reset_req=1: counter cleared.
  3. counter==STABLE_CYCLES-1: go to RUN, sys_rst falls on that edge.
  4. Otherwise the counter increments.
- RUN: pll_rst=0, sys_rst=0. Checks in priority order:
  1. locked_s=0: go to PLL_RESET; pll_rst and sys_rst rise and lock_lost is set, all on that edge.
  2. reset_req=1: go to STABLE; sys_rst rises on that edge and the PLL is not reset.
- reset_req is ignored in PLL_RESET and WAIT_LOCK, where sys_rst is already high.
- sys_rst is glitch-free: it is low only in RUN.
- rst_n asserted mid-sequence returns everything to the reset values immediately (asynchronous).
- Total release latency with lock already present: PLL_RST_CYCLES + 1 + STABLE_CYCLES edges after rst_n deassertion. Edge 1 is the first posedge with rst_n high.

Test Plan (bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8):
- Power-on, pll_locked=1 throughout, rst_n released -> pll_rst falls at edge 4; sys_rst falls at edge 13; lock_lost=0; retries=0.
- pll_locked held 0 -> pll_rst high edges 1-3, low edges 4-35, high again at edge 36 for 4 cycles; retries=1 after edge 36. After 20 timeouts retries stays at 15. sys_rst never falls.
- In RUN, pull pll_locked low for 1 cycle -> pll_rst and sys_rst rise 3 edges later (2 sync + 1 FSM); lock_lost=1 and stays 1; relock gives sys_rst release 13 edges after the PLL_RESET entry edge.
- In RUN, pulse reset_req for 1 cycle -> sys_rst high next edge for 8 cycles then falls; pll_rst stays 0; lock_lost unchanged. Holding reset_req for 20 cycles extends sys_rst until 8 cycles after reset_req drops.
- In STABLE at counter=5, pull pll_locked low for 3 cycles -> returns to WAIT_LOCK with no retry increment; sys_rst stays high; release occurs a full 8 STABLE cycles after relock.
- Assert rst_n low in RUN and in STABLE -> pll_rst=1, sys_rst=1, lock_lost=0, retries=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sys_reset_ctrl_if.sv
// -----------------------------------------------------------------------------
// sys_reset_ctrl_if
// Bundles the PLL supervision and system reset signals of sys_reset_ctrl.
//   pll_locked : PLL lock indication, asynchronous to clk
//   reset_req  : synchronous, level-sensitive soft-reset request
//   pll_rst    : active-high PLL reset
//   sys_rst    : active-high system reset
//   lock_lost  : sticky flag, lock dropped while running
//   retries    : saturating count of lock-timeout retries
// Modports:
//   slave  : the reset controller (consumes lock/request, drives resets)
//   master : the environment (PLL model / debug controller / consumers)
// -----------------------------------------------------------------------------
interface sys_reset_ctrl_if;
   logic       pll_locked;
   logic       reset_req;
   logic       pll_rst;
   logic       sys_rst;
   logic       lock_lost;
   logic [3:0] retries;

   modport slave (
      input  pll_locked,
      input  reset_req,
      output pll_rst,
      output sys_rst,
      output lock_lost,
      output retries
   );

   modport master (
      output pll_locked,
      output reset_req,
      input  pll_rst,
      input  sys_rst,
      input  lock_lost,
      input  retries
   );
endinterface : sys_reset_ctrl_if

// File: rtl/sys_reset_ctrl.sv
// -----------------------------------------------------------------------------
// sys_reset_ctrl
// Power-on and lock-supervision reset controller in front of the system PLL.
// Holds the PLL in reset, waits for lock (retrying on timeout), requires lock
// to be stable for a set time, then releases the system reset. Loss of lock
// while running restarts the whole sequence.
// Ports:
//   clk   : free-running reference clock (same as PLL refclk)
//   rst_n : asynchronous active-low reset
//   ctrl  : sys_reset_ctrl_if.slave (pll_locked, reset_req in;
//           pll_rst, sys_rst, lock_lost, retries out)
// All outputs are registered.
// -----------------------------------------------------------------------------
module sys_reset_ctrl #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int STABLE_CYCLES  = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   sys_reset_ctrl_if.slave   ctrl
);

   // One counter serves all timed states, so it is sized for the longest one.
   localparam int MAX_CYCLES =
      (PLL_RST_CYCLES > LOCK_TIMEOUT)
         ? ((PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES)
         : ((LOCK_TIMEOUT   > STABLE_CYCLES) ? LOCK_TIMEOUT   : STABLE_CYCLES);
   localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   localparam logic [CW-1:0] PLL_RST_LAST = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      PLL_RESET = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_e;

   state_e          r_state;
   state_e          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic            r_sync1;
   logic            r_sync2;
   logic            r_pll_rst;
   logic            w_pll_rst_nxt;
   logic            r_sys_rst;
   logic            w_sys_rst_nxt;
   logic            r_lock_lost;
   logic            w_lock_lost_nxt;
   logic [3:0]      r_retries;
   logic [3:0]      w_retries_nxt;
   logic            w_locked_s;

   assign w_locked_s = r_sync2;

   // --------------------------------------------------------------------------
   // State and output registers, including the lock synchroniser.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; blocking here would create order-dependent
   // behaviour between the synchroniser stages.
   // NOTE: every flop here is control state and has a defined reset value;
   // nothing is left to power-up contents.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= PLL_RESET;
         r_cnt       <= '0;
         r_sync1     <= 1'b0;
         r_sync2     <= 1'b0;
         r_pll_rst   <= 1'b1;
         r_sys_rst   <= 1'b1;
         r_lock_lost <= 1'b0;
         r_retries   <= 4'd0;
      end else begin
         r_sync1     <= ctrl.pll_locked;
         r_sync2     <= r_sync1;
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_pll_rst   <= w_pll_rst_nxt;
         r_sys_rst   <= w_sys_rst_nxt;
         r_lock_lost <= w_lock_lost_nxt;
         r_retries   <= w_retries_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // Next-state, counter and output decode.
   // NOTE: every signal gets a default before the case statement so no path
   // leaves it unassigned, which would otherwise infer a latch.
   // --------------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_lock_lost_nxt = r_lock_lost;
      w_retries_nxt   = r_retries;

      unique case (r_state)
         PLL_RESET: begin
            if (r_cnt == PLL_RST_LAST) begin
               w_state_nxt = WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end

         WAIT_LOCK: begin
            if (w_locked_s) begin
               w_state_nxt = STABLE;
               w_cnt_nxt   = '0;
            end else if (r_cnt == TIMEOUT_LAST) begin
               w_state_nxt = PLL_RESET;
               w_cnt_nxt   = '0;
               if (r_retries != 4'hF) begin
                  w_retries_nxt = r_retries + 4'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end

         STABLE: begin
            if (!w_locked_s) begin
               // Lock bounced before the system was released: wait again
               // without charging a retry.
               w_state_nxt = WAIT_LOCK;
               w_cnt_nxt   = '0;
            end else if (ctrl.reset_req) begin
               // Soft reset held: restart the stability window each cycle.
               w_cnt_nxt = '0;
            end else if (r_cnt == STABLE_LAST) begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end

         RUN: begin
            if (!w_locked_s) begin
               w_state_nxt     = PLL_RESET;
               w_cnt_nxt       = '0;
               w_lock_lost_nxt = 1'b1;
            end else if (ctrl.reset_req) begin
               // Soft reset re-enters STABLE: system held, PLL left running.
               w_state_nxt = STABLE;
               w_cnt_nxt   = '0;
            end
         end

         default: begin
            w_state_nxt = PLL_RESET;
            w_cnt_nxt   = '0;
         end
      endcase

      // Outputs decode from the next state so they change on the same edge
      // as the transition; sys_rst is low only in RUN, so it cannot glitch.
      w_pll_rst_nxt = (w_state_nxt == PLL_RESET);
      w_sys_rst_nxt = (w_state_nxt != RUN);
   end

   assign ctrl.pll_rst   = r_pll_rst;
   assign ctrl.sys_rst   = r_sys_rst;
   assign ctrl.lock_lost = r_lock_lost;
   assign ctrl.retries   = r_retries;

endmodule : sys_reset_ctrl

// File: tb/tb_sys_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sys_reset_ctrl
// Directed testbench for sys_reset_ctrl with PLL_RST_CYCLES=4, LOCK_TIMEOUT=32,
// STABLE_CYCLES=8. Edge numbers in comments count posedges after rst_n
// deassertion (edge 1 is the first posedge with rst_n high). Inputs change and
// outputs are sampled 1 ns after a posedge.
// -----------------------------------------------------------------------------
module tb_sys_reset_ctrl;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   sys_reset_ctrl_if bus_if ();

   sys_reset_ctrl #(
      .PLL_RST_CYCLES (4),
      .LOCK_TIMEOUT   (32),
      .STABLE_CYCLES  (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ctrl  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic pll_rst_e,
                            input logic sys_rst_e, input logic lock_lost_e,
                            input logic [3:0] retries_e);
      check({tag, ".pll_rst"},   32'(bus_if.pll_rst),   32'(pll_rst_e));
      check({tag, ".sys_rst"},   32'(bus_if.sys_rst),   32'(sys_rst_e));
      check({tag, ".lock_lost"}, 32'(bus_if.lock_lost), 32'(lock_lost_e));
      check({tag, ".retries"},   32'(bus_if.retries),   32'(retries_e));
   endtask

   initial begin
      bit released;
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b1;
      bus_if.pll_locked = 1'b1;
      bus_if.reset_req  = 1'b0;

      // ---------------- Reset values ----------------
      #1 rst_n = 1'b0;
      tick();
      tick();
      check_all("reset", 1'b1, 1'b1, 1'b0, 4'd0);

      // ---------------- Power-on with lock present ----------------
      rst_n = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         tick();
         check($sformatf("pwron.pll_rst.e%0d", k), 32'(bus_if.pll_rst), 32'(k < 4));
         check($sformatf("pwron.sys_rst.e%0d", k), 32'(bus_if.sys_rst), 32'(k < 13));
      end
      check_all("pwron.end", 1'b0, 1'b0, 1'b0, 4'd0);

      // ---------------- Lock loss in RUN (1-cycle glitch) ----------------
      bus_if.pll_locked = 1'b0;
      tick();                                    // E: sync stage 1 sees 0
      check_all("loss.e0", 1'b0, 1'b0, 1'b0, 4'd0);
      bus_if.pll_locked = 1'b1;
      tick();                                    // E+1
      check_all("loss.e1", 1'b0, 1'b0, 1'b0, 4'd0);
      tick();                                    // E+2: PLL_RESET entry
      check_all("loss.e2", 1'b1, 1'b1, 1'b1, 4'd0);
      for (int k = 1; k <= 13; k++) begin
         tick();
         check($sformatf("relock.pll_rst.e%0d", k), 32'(bus_if.pll_rst), 32'(k < 4));
         check($sformatf("relock.sys_rst.e%0d", k), 32'(bus_if.sys_rst), 32'(k < 13));
         check($sformatf("relock.lock_lost.e%0d", k), 32'(bus_if.lock_lost), 32'd1);
      end

      // ---------------- reset_req pulse in RUN ----------------
      bus_if.reset_req = 1'b1;
      tick();                                    // R: into STABLE
      check_all("req.r0", 1'b0, 1'b1, 1'b1, 4'd0);
      bus_if.reset_req = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("req.sys_rst.e%0d", k), 32'(bus_if.sys_rst), 32'(k < 8));
         check($sformatf("req.pll_rst.e%0d", k), 32'(bus_if.pll_rst), 32'd0);
      end
      check("req.lock_lost", 32'(bus_if.lock_lost), 32'd1);

      // ---------------- reset_req held 20 cycles ----------------
      bus_if.reset_req = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         check($sformatf("hold.sys_rst.e%0d", k), 32'(bus_if.sys_rst), 32'd1);
      end
      bus_if.reset_req = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("hold.rel.sys_rst.e%0d", k), 32'(bus_if.sys_rst), 32'(k < 8));
         check($sformatf("hold.rel.pll_rst.e%0d", k), 32'(bus_if.pll_rst), 32'd0);
      end

      // ---------------- Lock drop in STABLE at counter 5 ----------------
      bus_if.reset_req = 1'b1;
      tick();                                    // R: STABLE, cnt=0
      bus_if.reset_req = 1'b0;
      tick();
      tick();
      tick();                                    // R+3: cnt=3
      bus_if.pll_locked = 1'b0;                  // low for edges R+4..R+6
      for (int k = 0; k <= 13; k++) begin
         tick();                                 // edge R+4+k
         check($sformatf("sdrop.sys_rst.e%0d", k), 32'(bus_if.sys_rst), 32'(k < 13));
         check($sformatf("sdrop.pll_rst.e%0d", k), 32'(bus_if.pll_rst), 32'd0);
         if (k == 2) bus_if.pll_locked = 1'b1;
      end
      check_all("sdrop.end", 1'b0, 1'b0, 1'b1, 4'd0);

      // ---------------- Lock timeouts from power-on ----------------
      rst_n = 1'b0;
      bus_if.pll_locked = 1'b0;
      #1;
      check_all("to.async_rst", 1'b1, 1'b1, 1'b0, 4'd0);
      #1 rst_n = 1'b1;
      for (int k = 1; k <= 740; k++) begin
         tick();
         check($sformatf("to.pll_rst.e%0d", k), 32'(bus_if.pll_rst), 32'((k % 36) < 4));
         check($sformatf("to.sys_rst.e%0d", k), 32'(bus_if.sys_rst), 32'd1);
         check($sformatf("to.retries.e%0d", k), 32'(bus_if.retries),
               ((k / 36) > 15) ? 32'd15 : 32'(k / 36));
      end

      // ---------------- Async reset in RUN ----------------
      bus_if.pll_locked = 1'b1;
      released = 1'b0;
      for (int k = 0; k < 60 && !released; k++) begin
         tick();
         if (bus_if.sys_rst == 1'b0) released = 1'b1;
      end
      check("run.reached", 32'(released), 32'd1);
      check_all("run.pre", 1'b0, 1'b0, 1'b0, 4'd15);
      #2 rst_n = 1'b0;
      #1;
      check_all("run.async_rst", 1'b1, 1'b1, 1'b0, 4'd0);

      // ---------------- Async reset in STABLE ----------------
      rst_n = 1'b1;
      for (int k = 1; k <= 9; k++) tick();       // STABLE entered at edge 5
      check_all("stable.pre", 1'b0, 1'b1, 1'b0, 4'd0);
      #2 rst_n = 1'b0;
      #1;
      check_all("stable.async_rst", 1'b1, 1'b1, 1'b0, 4'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_sys_reset_ctrl
